// File: rtl/axi_pc_port_scheduler.sv
// Time-shares one AXI protocol checker across NUM_PORTS monitored ports: tracks
// outstanding traffic per port, attaches only at quiescent boundaries, latches the first error.
module axi_pc_port_scheduler #(
  parameter int NUM_PORTS     = 4,
  parameter int SEL_W         = 2,
  parameter int CNT_W         = 8,
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter bit HALT_ON_ERR   = 1'b1
) (
  input  logic                 aclk_i,
  input  logic                 areset_i,
  input  logic                 cfg_enable_i,
  input  logic [31:0]          cfg_dwell_i,
  input  logic [NUM_PORTS-1:0] mon_awvalid_i,
  input  logic [NUM_PORTS-1:0] mon_awready_i,
  input  logic [NUM_PORTS-1:0] mon_wvalid_i,
  input  logic [NUM_PORTS-1:0] mon_wready_i,
  input  logic [NUM_PORTS-1:0] mon_wlast_i,
  input  logic [NUM_PORTS-1:0] mon_bvalid_i,
  input  logic [NUM_PORTS-1:0] mon_bready_i,
  input  logic [NUM_PORTS-1:0] mon_arvalid_i,
  input  logic [NUM_PORTS-1:0] mon_arready_i,
  input  logic [NUM_PORTS-1:0] mon_rvalid_i,
  input  logic [NUM_PORTS-1:0] mon_rready_i,
  input  logic [NUM_PORTS-1:0] mon_rlast_i,
  input  logic [159:0]         pc_status_i,
  input  logic                 pc_asserted_i,
  output logic [SEL_W-1:0]     pc_sel_o,
  output logic                 pc_aresetn_o,
  output logic                 pc_attached_o,
  output logic                 err_valid_o,
  output logic [SEL_W-1:0]     err_port_o,
  output logic [159:0]         err_status_o,
  input  logic                 err_ack_i,
  output logic                 err_dropped_o,
  output logic                 cnt_overflow_o
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [SEL_W-1:0] LAST_PORT = SEL_W'(NUM_PORTS - 1);
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] U_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] S_MAX     = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] S_MIN     = {1'b1, {(CNT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_DRAIN    = 2'd0,
    ST_RESET_PC = 2'd1,
    ST_MONITOR  = 2'd2
  } state_e;

  logic [NUM_PORTS-1:0] quiet;
  logic [NUM_PORTS-1:0] sat_any;

  // Per-port outstanding counters; w_out is two's complement because W data may lead AW.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic             aw_hs, b_hs, wl_hs, ar_hs, rl_hs;
    logic [CNT_W-1:0] aw_q, aw_d, w_q, w_d, ar_q, ar_d;
    logic             sat_aw, sat_w, sat_ar;

    assign aw_hs = mon_awvalid_i[gi] & mon_awready_i[gi];
    assign b_hs  = mon_bvalid_i[gi]  & mon_bready_i[gi];
    assign wl_hs = mon_wvalid_i[gi]  & mon_wready_i[gi] & mon_wlast_i[gi];
    assign ar_hs = mon_arvalid_i[gi] & mon_arready_i[gi];
    assign rl_hs = mon_rvalid_i[gi]  & mon_rready_i[gi] & mon_rlast_i[gi];

    always_comb begin
      aw_d   = aw_q;
      sat_aw = 1'b0;
      if (aw_hs && !b_hs) begin
        if (aw_q == U_MAX) sat_aw = 1'b1;
        else               aw_d   = aw_q + 1'b1;
      end else if (b_hs && !aw_hs) begin
        if (aw_q == '0)    sat_aw = 1'b1;
        else               aw_d   = aw_q - 1'b1;
      end
    end

    always_comb begin
      w_d   = w_q;
      sat_w = 1'b0;
      if (aw_hs && !wl_hs) begin
        if (w_q == S_MAX) sat_w = 1'b1;
        else              w_d   = w_q + 1'b1;
      end else if (wl_hs && !aw_hs) begin
        if (w_q == S_MIN) sat_w = 1'b1;
        else              w_d   = w_q - 1'b1;
      end
    end

    always_comb begin
      ar_d   = ar_q;
      sat_ar = 1'b0;
      if (ar_hs && !rl_hs) begin
        if (ar_q == U_MAX) sat_ar = 1'b1;
        else               ar_d   = ar_q + 1'b1;
      end else if (rl_hs && !ar_hs) begin
        if (ar_q == '0)    sat_ar = 1'b1;
        else               ar_d   = ar_q - 1'b1;
      end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
      if (areset_i) begin
        aw_q <= '0;
        w_q  <= '0;
        ar_q <= '0;
      end else begin
        aw_q <= aw_d;
        w_q  <= w_d;
        ar_q <= ar_d;
      end
    end

    assign quiet[gi] = (aw_q == '0) && (w_q == '0) && (ar_q == '0) &&
                       !mon_awvalid_i[gi] && !mon_wvalid_i[gi] && !mon_arvalid_i[gi];
    assign sat_any[gi] = sat_aw | sat_w | sat_ar;
  end

  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
    return (p >= LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] cand_q, cand_d;
  logic [31:0]      dwell_q, dwell_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             aresetn_q, attached_q;
  logic             err_valid_q, err_valid_d;
  logic [SEL_W-1:0] err_port_q, err_port_d;
  logic [159:0]     err_status_q, err_status_d;
  logic             err_dropped_q, err_dropped_d;
  logic             ovf_q;

  logic [31:0] dwell_lim;
  logic [31:0] dwell_inc;
  logic        err_hit;
  logic        ack_ok;

  assign dwell_lim = (cfg_dwell_i == 32'd0) ? 32'd1 : cfg_dwell_i;
  assign dwell_inc = (&dwell_q) ? dwell_q : dwell_q + 32'd1;

  // The dwell comparison uses the count including the current cycle, so MONITOR lasts cfg_dwell cycles.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cand_d    = cand_q;
    dwell_d   = dwell_q;
    tmo_d     = tmo_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      ST_MONITOR: begin
        dwell_d = dwell_inc;
        if ((dwell_inc >= dwell_lim) && cfg_enable_i && !(HALT_ON_ERR && err_valid_q)) begin
          state_d = ST_DRAIN;
          cand_d  = next_port(sel_q);
          tmo_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (quiet[cand_q]) begin
          state_d   = ST_RESET_PC;
          sel_d     = cand_q;
          rst_cnt_d = '0;
        end else if (tmo_q >= TMO_LAST) begin
          cand_d = next_port(cand_q);
          tmo_d  = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_RESET_PC: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_MONITOR;
          dwell_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_DRAIN;
    endcase
  end

  assign err_hit = attached_q && pc_asserted_i;
  assign ack_ok  = err_ack_i && err_valid_q;

  // An ack in the same cycle as a new assertion frees the slot for the new record.
  always_comb begin
    err_valid_d   = err_valid_q;
    err_port_d    = err_port_q;
    err_status_d  = err_status_q;
    err_dropped_d = err_dropped_q;
    if (err_hit) begin
      if (!err_valid_q || ack_ok) begin
        err_valid_d  = 1'b1;
        err_port_d   = sel_q;
        err_status_d = pc_status_i;
      end else begin
        err_dropped_d = 1'b1;
      end
    end else if (ack_ok) begin
      err_valid_d   = 1'b0;
      err_dropped_d = 1'b0;
    end
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q       <= ST_DRAIN;
      sel_q         <= '0;
      cand_q        <= '0;
      dwell_q       <= '0;
      tmo_q         <= '0;
      rst_cnt_q     <= '0;
      aresetn_q     <= 1'b0;
      attached_q    <= 1'b0;
      err_valid_q   <= 1'b0;
      err_port_q    <= '0;
      err_status_q  <= '0;
      err_dropped_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      cand_q        <= cand_d;
      dwell_q       <= dwell_d;
      tmo_q         <= tmo_d;
      rst_cnt_q     <= rst_cnt_d;
      aresetn_q     <= (state_d == ST_MONITOR);
      attached_q    <= (state_d == ST_MONITOR);
      err_valid_q   <= err_valid_d;
      err_port_q    <= err_port_d;
      err_status_q  <= err_status_d;
      err_dropped_q <= err_dropped_d;
      ovf_q         <= ovf_q | (|sat_any);
    end
  end

  assign pc_sel_o       = sel_q;
  assign pc_aresetn_o   = aresetn_q;
  assign pc_attached_o  = attached_q;
  assign err_valid_o    = err_valid_q;
  assign err_port_o     = err_port_q;
  assign err_status_o   = err_status_q;
  assign err_dropped_o  = err_dropped_q;
  assign cnt_overflow_o = ovf_q;

endmodule
